// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FSM state and I/Q lane-index definitions for the overlap buffer
package fft_pkg;

    typedef enum logic {
        REPLAY = 1'b0,
        PASS   = 1'b1
    } fsm_state_t;

    // Component order inside a packed {Q, I} history word
    localparam int IDX_I    = 0;
    localparam int IDX_Q    = 1;
    localparam int NUM_COMP = 2;

endpackage

// File: rtl/fft_hist_ram.sv
// rtl/fft_hist_ram.sv - frame history store: one write port, one async read port, sync clear
module fft_hist_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_hl_overlap_buf.sv
// rtl/fft_hl_overlap_buf.sv - builds NBEAT-beat frames whose first ov beats replay the previous frame's tail
module fft_hl_overlap_buf
    import fft_pkg::*;
#(
    parameter int NBW_IN = 9,
    parameter int NS_IN  = 64,
    parameter int NBEAT  = 8,
    parameter int NBW_OV = $clog2(NBEAT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NBW_OV-1:0]         i_overlap,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic signed [NS_IN*NBW_IN-1:0] i_data_i,
    input  logic signed [NS_IN*NBW_IN-1:0] i_data_q,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic signed [NS_IN*NBW_IN-1:0] o_data_i,
    output logic signed [NS_IN*NBW_IN-1:0] o_data_q,
    output logic                      o_hi_lo_flag,
    output logic                      o_sof
);

    localparam int KW = $clog2(NBEAT);
    localparam int BW = NS_IN * NBW_IN;
    localparam int HW = NUM_COMP * BW;

    fsm_state_t    state, state_nxt, mode;
    logic [KW-1:0] k, k_nxt, ov_q, ov_in, ov_cur, raddr;
    logic          can_load, load;
    logic [HW-1:0] hist_rd, beat;

    always_comb begin
        if (32'(i_overlap) >= NBEAT) begin
            ov_in = KW'(NBEAT - 1);
        end else begin
            ov_in = KW'(i_overlap);
        end
    end

    assign k_nxt = k + KW'(1);
    // Slot NBEAT-ov+k of the previous frame; wraps naturally since NBEAT is a power of 2
    assign raddr = k - ov_cur;

    // At frame beat 0 the live overlap decides the mode, since ov_q is only captured on that load
    always_comb begin
        mode      = state;
        ov_cur    = ov_q;
        state_nxt = state;
        if (k == '0) begin
            ov_cur = ov_in;
            mode   = (ov_in != '0) ? REPLAY : PASS;
        end
        can_load = !o_valid || i_ready;
        o_ready  = !rst && (mode == PASS) && can_load;
        load     = !rst && can_load && ((mode == REPLAY) || i_valid);
        if (load) begin
            if (k == KW'(NBEAT - 1)) begin
                state_nxt = (ov_in != '0) ? REPLAY : PASS;
            end else begin
                state_nxt = (k_nxt < ov_cur) ? REPLAY : PASS;
            end
        end
    end

    always_comb begin
        beat = hist_rd;
        if (mode == PASS) begin
            beat[IDX_I*BW +: BW] = i_data_i;
            beat[IDX_Q*BW +: BW] = i_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PASS;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid      <= 1'b0;
            o_sof        <= 1'b0;
            o_hi_lo_flag <= 1'b0;
            o_data_i     <= '0;
            o_data_q     <= '0;
            k            <= '0;
            ov_q         <= '0;
        end else if (load) begin
            o_valid      <= 1'b1;
            o_sof        <= (k == '0);
            o_hi_lo_flag <= (k >= KW'(NBEAT / 2));
            o_data_i     <= beat[IDX_I*BW +: BW];
            o_data_q     <= beat[IDX_Q*BW +: BW];
            k            <= k_nxt;
            if (k == '0) begin
                ov_q <= ov_in;
            end
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

    // The replay read (slot k-ov) always targets a slot not yet rewritten in this frame
    fft_hist_ram #(
        .DEPTH (NBEAT),
        .WIDTH (HW)
    ) u_hist (
        .clk   (clk),
        .rst   (rst),
        .we    (load),
        .waddr (k),
        .wdata (beat),
        .raddr (raddr),
        .rdata (hist_rd)
    );

endmodule

// File: tb/tb_fft_hl_overlap_buf.sv
// tb/tb_fft_hl_overlap_buf.sv - scoreboard bench for fft_hl_overlap_buf with directed frame vectors
module tb_fft_hl_overlap_buf;

    localparam int NBW_IN = 9;
    localparam int NS_IN  = 4;
    localparam int NBEAT  = 8;
    localparam int NBW_OV = 3;
    localparam int BW     = NBW_IN * NS_IN;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NBW_OV-1:0]    i_overlap = '0;
    logic                 i_valid = 1'b0;
    logic                 o_ready;
    logic signed [BW-1:0] i_data_i = '0;
    logic signed [BW-1:0] i_data_q = '0;
    logic                 o_valid;
    logic                 i_ready = 1'b1;
    logic signed [BW-1:0] o_data_i;
    logic signed [BW-1:0] o_data_q;
    logic                 o_hi_lo_flag;
    logic                 o_sof;

    fft_hl_overlap_buf #(
        .NBW_IN (NBW_IN),
        .NS_IN  (NS_IN),
        .NBEAT  (NBEAT),
        .NBW_OV (NBW_OV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_overlap    (i_overlap),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data_i     (i_data_i),
        .i_data_q     (i_data_q),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data_i     (o_data_i),
        .o_data_q     (o_data_q),
        .o_hi_lo_flag (o_hi_lo_flag),
        .o_sof        (o_sof)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        bit sof;
        bit hi;
    } exp_t;

    exp_t exp_q[$];
    int   in_q[$];
    int   exp_vals[$];
    int   checks = 0;
    int   errors = 0;
    int   out_cnt = 0;
    int   low_cnt = 0;
    bit   cnt_en = 1'b0;
    bit   stall_en = 1'b0;
    bit   acc = 1'b0;

    // Beat value 0 stands for an all-zero (reset history) beat
    function automatic logic [BW-1:0] mk_i(input int v);
        logic [BW-1:0] r;
        r = '0;
        if (v != 0) begin
            for (int j = 0; j < NS_IN; j++) r[j*NBW_IN +: NBW_IN] = NBW_IN'(v * 4 + j);
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] mk_q(input int v);
        logic [BW-1:0] r;
        r = '0;
        if (v != 0) begin
            for (int j = 0; j < NS_IN; j++) r[j*NBW_IN +: NBW_IN] = NBW_IN'(-(v * 2) - j * 3);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Driver: presents the head of in_q, pops it once the previous cycle's handshake completed
    initial begin
        forever begin
            @(negedge clk);
            if (acc && in_q.size() > 0) void'(in_q.pop_front());
            i_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_q.size() > 0) begin
                i_valid  = 1'b1;
                i_data_i = mk_i(in_q[0]);
                i_data_q = mk_q(in_q[0]);
            end else begin
                i_valid = 1'b0;
            end
            #1;
            acc = i_valid && o_ready;
            if (cnt_en && !rst && !o_ready) low_cnt++;
        end
    end

    // Monitor: scoreboard compare on each output transfer, plus hold check after stalls
    initial begin
        exp_t e;
        bit prev_stall;
        logic [BW-1:0] pi, pq;
        logic psof, phi;
        prev_stall = 1'b0;
        pi = '0; pq = '0; psof = 1'b0; phi = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (o_valid !== 1'b1 || o_data_i !== pi || o_data_q !== pq || o_sof !== psof || o_hi_lo_flag !== phi) begin
                        errors++;
                        $display("FAIL hold v=%b i=%h q=%h sof=%b hi=%b want i=%h q=%h sof=%b hi=%b",
                                 o_valid, o_data_i, o_data_q, o_sof, o_hi_lo_flag, pi, pq, psof, phi);
                    end
                end
                if (o_valid && i_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out i=%h q=%h sof=%b", o_data_i, o_data_q, o_sof);
                    end else begin
                        e = exp_q.pop_front();
                        if (o_data_i !== mk_i(e.v) || o_data_q !== mk_q(e.v) || o_sof !== e.sof || o_hi_lo_flag !== e.hi) begin
                            errors++;
                            $display("FAIL out[%0d] got i=%h q=%h sof=%b hi=%b want v=%0d i=%h q=%h sof=%b hi=%b",
                                     out_cnt, o_data_i, o_data_q, o_sof, o_hi_lo_flag,
                                     e.v, mk_i(e.v), mk_q(e.v), e.sof, e.hi);
                        end
                    end
                    out_cnt++;
                end
                prev_stall = o_valid && !i_ready;
                pi = o_data_i; pq = o_data_q; psof = o_sof; phi = o_hi_lo_flag;
            end
        end
    end

    task automatic push_scn(input int nfresh);
        exp_t e;
        foreach (exp_vals[i]) begin
            e.v   = exp_vals[i];
            e.sof = ((i % NBEAT) == 0);
            e.hi  = ((i % NBEAT) >= NBEAT / 2);
            exp_q.push_back(e);
        end
        for (int v = 1; v <= nfresh; v++) in_q.push_back(v);
    endtask

    task automatic start_scn(input int ov);
        @(negedge clk);
        rst = 1'b1;
        i_overlap = '0;
        @(negedge clk);
        rst = 1'b0;
        out_cnt = 0;
        i_overlap = NBW_OV'(ov);
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (out_cnt < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("wait_out_count_reached", 64'(out_cnt >= n), 64'(1));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || in_q.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 64'(exp_q.size() + in_q.size()), 64'(0));
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_o_valid", 64'(o_valid), 64'(0));
        chk("rst_o_ready", 64'(o_ready), 64'(0));
        chk("rst_o_sof", 64'(o_sof), 64'(0));
        chk("rst_o_hi_lo_flag", 64'(o_hi_lo_flag), 64'(0));
        chk("rst_o_data_i", 64'(o_data_i), 64'(0));
        chk("rst_o_data_q", 64'(o_data_q), 64'(0));

        // ov=0: straight pass-through, never back-pressured
        start_scn(0);
        exp_vals = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
        push_scn(16);
        low_cnt = 0; cnt_en = 1'b1;
        wait_drain();
        cnt_en = 1'b0;
        chk("ov0_ready_low_cycles", 64'(low_cnt), 64'(0));

        // ov=3 continuous
        start_scn(3);
        exp_vals = '{0, 0, 0, 1, 2, 3, 4, 5, 3, 4, 5, 6, 7, 8, 9, 10, 8, 9, 10, 11, 12, 13, 14, 15};
        push_scn(15);
        low_cnt = 0; cnt_en = 1'b1;
        wait_out(17);
        i_overlap = '0;
        wait_drain();
        cnt_en = 1'b0;
        chk("ov3_ready_low_cycles", 64'(low_cnt), 64'(9));

        // ov=7: one fresh beat per frame
        start_scn(7);
        exp_vals = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1, 2, 3};
        push_scn(3);
        wait_out(17);
        i_overlap = '0;
        wait_drain();

        // overlap 2 -> 5 changed mid-frame takes effect on the next frame only
        start_scn(2);
        exp_vals = '{0, 0, 1, 2, 3, 4, 5, 6, 2, 3, 4, 5, 6, 7, 8, 9};
        push_scn(9);
        wait_out(5);
        i_overlap = 3'd5;
        wait_out(9);
        i_overlap = '0;
        wait_drain();

        // ov=3 under random output stalls
        stall_en = 1'b1;
        start_scn(3);
        exp_vals = '{0, 0, 0, 1, 2, 3, 4, 5, 3, 4, 5, 6, 7, 8, 9, 10, 8, 9, 10, 11, 12, 13, 14, 15};
        push_scn(15);
        wait_out(17);
        i_overlap = '0;
        wait_drain();
        stall_en = 1'b0;

        // reset mid-frame at beat 5, then a clean frame restarting from zeros
        start_scn(3);
        exp_vals = '{0, 0, 0, 1, 2, 3, 4, 5, 3, 4, 5, 6, 7, 8, 9, 10};
        push_scn(10);
        wait_out(5);
        rst = 1'b1;
        exp_q.delete();
        in_q.delete();
        @(negedge clk);
        chk("midrst_o_valid", 64'(o_valid), 64'(0));
        chk("midrst_o_sof", 64'(o_sof), 64'(0));
        rst = 1'b0;
        out_cnt = 0;
        exp_vals = '{0, 0, 0, 1, 2, 3, 4, 5};
        push_scn(5);
        wait_out(1);
        i_overlap = '0;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_hl_overlap_buf.md
FFT_HL_OVERLAP_BUF -- requirements
Module: fft_hl_overlap_buf

Interface
REQ-001 SHALL have parameter NBW_IN, default 9, sample width per I/Q component (signed).
REQ-002 SHALL have parameter NS_IN, default 64, complex lanes per beat.
REQ-003 SHALL have parameter NBEAT, default 8, beats per output frame; a power of 2, at least 2.
REQ-004 SHALL have parameter NBW_OV, default $clog2(NBEAT), width of the overlap control.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port i_overlap, input, NBW_OV, overlap beats per frame (0..NBEAT-1).
REQ-008 SHALL have ports i_valid (input, 1) and o_ready (output, 1) for the input handshake.
REQ-009 SHALL have ports i_data_i and i_data_q, input, signed NBW_IN x NS_IN, input beat.
REQ-010 SHALL have ports o_valid (output, 1) and i_ready (input, 1) for the output handshake.
REQ-011 SHALL have ports o_data_i and o_data_q, output, signed NBW_IN x NS_IN, output beat.
REQ-012 SHALL have port o_hi_lo_flag, output, 1: 0 = lower half of frame, 1 = upper half.
REQ-013 SHALL have port o_sof, output, 1: marks beat 0 of an output frame.

Function
REQ-014 SHALL emit frames of NBEAT beats: first ov replayed beats, then NBEAT-ov fresh input beats.
REQ-015 SHALL replay, at frame beat k<ov, the beat emitted at position NBEAT-ov+k of the previous frame.
REQ-016 SHALL sample i_overlap into ov_q only when frame beat 0 is accepted into the output register; mid-frame changes are ignored.
REQ-017 SHALL treat i_overlap >= NBEAT as saturating to NBEAT-1.
REQ-018 SHALL implement FSM REPLAY/PASS: beat 0 enters REPLAY if ov_q>0, else PASS; REPLAY goes to PASS after ov_q beats; PASS goes to REPLAY/PASS after the beat at position NBEAT-1.
REQ-019 SHALL drive o_ready=0 in REPLAY; in PASS, o_ready = (!o_valid || i_ready).
REQ-020 SHALL register the output with one stage; it loads on (!o_valid || i_ready) when a beat is available (a replay beat, or i_valid&&o_ready).
REQ-021 SHALL give 1-cycle latency from the input accept to o_valid, with no bubble under continuous i_valid and i_ready.
REQ-022 SHALL hold o_data_*, o_hi_lo_flag and o_sof stable while o_valid && !i_ready.
REQ-023 SHALL write every emitted beat, replayed or fresh, into history slot k (k = frame position) of an NBEAT-entry buffer; read-before-write at a slot SHALL be guaranteed by ordering.
REQ-024 SHALL set o_hi_lo_flag = (k >= NBEAT/2); o_sof = (k == 0).
REQ-025 SHALL increment the beat counter k modulo NBEAT on each load of the output register, wrapping from NBEAT-1 to 0.
REQ-026 SHALL make the first frame after reset replay zeros for its ov beats, because the history resets to 0.
REQ-027 SHALL pass data unchanged (no scaling/rounding); the output width equals the input width.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, clear o_valid, o_sof, o_hi_lo_flag, o_data_*, k, ov_q and all history to 0, with the FSM going to PASS.
REQ-029 SHALL drive o_ready=0 while rst=1; reset mid-frame SHALL discard the partial frame, and the next accepted beat is frame beat 0.

Structure
REQ-030 SHALL place the FSM state enum (REPLAY, PASS) and the I/Q index constants in shared package fft_pkg.
REQ-031 SHALL implement the history store as sub-module fft_hist_ram (NBEAT x 2*NS_IN*NBW_IN, 1 write and 1 async read port, sync clear).

Verification
REQ-032 SHALL verify ov=0, NBEAT=8, beats with ramp values 1..16, continuous: output equals input delayed 1 cycle; o_sof on values 1 and 9; flag=1 on values 5-8 and 13-16.
REQ-033 SHALL verify ov=3, NBEAT=8, input 1..15: frame0 = 0,0,0,1..5; frame1 = 3,4,5,6..10; o_ready low for 3 cycles per frame.
REQ-034 SHALL verify ov=7: each frame carries 1 fresh beat; frame n+1 beats 0..6 equal frame n beats 1..7.
REQ-035 SHALL verify i_overlap changed 2->5 at frame beat 4: the current frame is unaffected; the next frame replays 5 beats.
REQ-036 SHALL verify random i_ready stalls (50%) at ov=3: the sequence matches the no-stall run exactly, and outputs are held during stalls.
REQ-037 SHALL verify rst pulsed at frame beat 5: o_valid=0 the next cycle; the next frame starts with o_sof=1 and replays ov zero beats.
